// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NREQ requesters.
// Define CMP_SIGNED_EN for a two's-complement compare (default is unsigned).
module cmp_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  Lesser,
  output logic                  Greater,
  output logic                  Equal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_RESP
  } state_e;

  state_e           r_state;
  state_e           w_next;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_lt;
  logic             r_gt;
  logic             r_eq;

  logic             w_found;
  logic [IDW-1:0]   w_gnt;
  logic [IDW:0]     w_idx;
  logic             w_take;
  logic             w_rsp_hs;
  logic             w_lt;
  logic             w_eq;

  // Search from r_ptr upward, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ))
        w_idx = w_idx - (IDW+1)'(NREQ);
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[IDW-1:0];
      end
    end
  end

  assign w_take   = (r_state == S_IDLE) && w_found && !rst;
  assign w_rsp_hs = (r_state == S_RESP) && rsp_ready;

  assign w_eq = (r_a == r_b);
`ifdef CMP_SIGNED_EN
  assign w_lt = $signed(r_a) < $signed(r_b);
`else
  assign w_lt = r_a < r_b;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_take) w_next = S_CMP;
      S_CMP:  w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (w_take)
      req_ready[w_gnt] = 1'b1;
    rsp_valid = (r_state == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_lt  <= 1'b0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
    end else begin
      if (w_take) begin
        r_a  <= req_a[w_gnt*WIDTH +: WIDTH];
        r_b  <= req_b[w_gnt*WIDTH +: WIDTH];
        r_id <= w_gnt;
      end
      if (r_state == S_CMP) begin
        r_lt <= w_lt;
        r_gt <= !w_lt && !w_eq;
        r_eq <= w_eq;
      end
      if (w_rsp_hs)
        r_ptr <= (r_id == IDW'(NREQ-1)) ? '0 : r_id + 1'b1;
    end
  end

  assign rsp_id  = r_id;
  assign Lesser  = r_lt;
  assign Greater = r_gt;
  assign Equal   = r_eq;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scenario bench for cmp_share_arbiter with a response scoreboard.
// Expectations are queued at each request handshake and popped on responses.
module tb_cmp_share_arbiter;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic           Lesser;
  logic           Greater;
  logic           Equal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic l;
    logic g;
    logic e;
  } exp_t;

  exp_t   exp_q[$];
  int     gnt_q[$];
  longint gtime_q[$];

  cmp_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .Lesser(Lesser), .Greater(Greater), .Equal(Equal)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int id, logic [W-1:0] a, logic [W-1:0] b);
    exp_t r;
    r.id = id[IDW-1:0];
    r.e  = (a == b);
`ifdef CMP_SIGNED_EN
    r.l  = $signed(a) < $signed(b);
`else
    r.l  = a < b;
`endif
    r.g  = !r.l && !r.e;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back(model(i, req_a[i*W +: W], req_b[i*W +: W]));
          gnt_q.push_back(i);
          gtime_q.push_back(longint'($time));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    checks++;
    if ({rsp_id, Lesser, Greater, Equal} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got id=%0d lge=%b%b%b want 0 000",
               rsp_id, Lesser, Greater, Equal);
    end
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single(input string name, input int id,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] lge);
    logic [N-1:0] oh;
    exp_t want;
    exp_t got;
    oh = '0;
    oh[id] = 1'b1;
    @(posedge clk); #1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== oh) begin
      errors++; $display("FAIL %s_ready: got %b want %b", name, req_ready, oh);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s_lat1: got rsp_valid=%b want 0", name, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL %s_lat2: got rsp_valid=%b want 1", name, rsp_valid);
    end
    got = {rsp_id, Lesser, Greater, Equal};
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s_sb: got empty scoreboard want 1 entry", name);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++; $display("FAIL %s_rsp: got %b want %b", name, got, want);
      end
    end
    checks++;
    if ({Lesser, Greater, Equal} !== lge || rsp_id !== id[IDW-1:0]) begin
      errors++;
      $display("FAIL %s_flags: got id=%0d lge=%b want id=%0d lge=%b",
               name, rsp_id, {Lesser, Greater, Equal}, id, lge);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s_idle: got rsp_valid=%b want 0", name, rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    exp_t want;
    exp_t got;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    gnt_q.delete();
    gtime_q.delete();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i * 10);
      req_b[i*W +: W] = W'(20);
    end
    req_valid = '1;
    for (int c = 0; c < 40 && gnt_q.size() < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = {rsp_id, Lesser, Greater, Equal};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++; $display("FAIL rr_rsp: got %b want %b", got, want);
        end
      end
    end
    req_valid = '0;
    checks++;
    if (gnt_q.size() < 5) begin
      errors++; $display("FAIL rr_timeout: got %0d grants want 5", gnt_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (gnt_q[k] !== k % N) begin
          errors++; $display("FAIL rr_order%0d: got %0d want %0d", k, gnt_q[k], k % N);
        end
      end
      for (int k = 1; k < 5; k++) begin
        checks++;
        if (gtime_q[k] - gtime_q[k-1] !== 64'sd30) begin
          errors++;
          $display("FAIL rr_spacing%0d: got %0d want 30", k, gtime_q[k] - gtime_q[k-1]);
        end
      end
    end
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = {rsp_id, Lesser, Greater, Equal};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++; $display("FAIL rr_drain: got %b want %b", got, want);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_left: got %0d pending want 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    exp_t want;
    exp_t got;
    bit seen;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_a[1*W +: W] = 32'd5;
    req_b[1*W +: W] = 32'd9;
    req_valid[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_grant: got %b want 0010", req_ready);
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    req_a[0 +: W] = 32'd3;
    req_b[0 +: W] = 32'd3;
    req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    checks++;
    if (!seen || exp_q.size() == 0) begin
      errors++; $display("FAIL bp_timeout: got rsp_valid=%b want 1", rsp_valid);
    end else begin
      want = exp_q.pop_front();
      checks++;
      if ({Lesser, Greater, Equal} !== 3'b100) begin
        errors++; $display("FAIL bp_flags: got %b want 100", {Lesser, Greater, Equal});
      end
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        got = {rsp_id, Lesser, Greater, Equal};
        checks++;
        if (rsp_valid !== 1'b1 || got !== want || req_ready !== 4'b0000) begin
          errors++;
          $display("FAIL bp_hold%0d: got v=%b rsp=%b rdy=%b want v=1 rsp=%b rdy=0000",
                   c, rsp_valid, got, req_ready, want);
        end
      end
    end
    rsp_ready = 1'b1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=0000", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid;
    exp_t want;
    exp_t got;
    bit seen;
    @(posedge clk); #1;
    req_a[3*W +: W] = 32'd1;
    req_b[3*W +: W] = 32'd2;
    req_valid[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL rm_grant: got %b want 1000", req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid[3] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, Lesser, Greater, Equal} !== 6'b0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL rm_clear: got v=%b id=%0d lge=%b%b%b rdy=%b want all 0",
               rsp_valid, rsp_id, Lesser, Greater, Equal, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL rm_noresp: got rsp_valid=1 want 0");
    end
    @(posedge clk); #1;
    req_a[0 +: W] = 32'd7;
    req_b[0 +: W] = 32'd7;
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rm_ptr: got %b want 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    checks++;
    if (!seen || exp_q.size() == 0) begin
      errors++; $display("FAIL rm_timeout: got rsp_valid=%b want 1", rsp_valid);
    end else begin
      want = exp_q.pop_front();
      got = {rsp_id, Lesser, Greater, Equal};
      checks++;
      if (got !== want || got !== 5'b00001) begin
        errors++; $display("FAIL rm_rsp: got %b want %b", got, 5'b00001);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single("equal", 0, 32'd2, 32'd2, 3'b001);
    test_single("lesser", 1, 32'd22, 32'd444, 3'b100);
    test_single("greater", 2, 32'd777, 32'd111, 3'b010);
`ifdef CMP_SIGNED_EN
    test_single("boundary", 3, 32'hFFFF_FFFF, 32'd1, 3'b100);
`else
    test_single("boundary", 3, 32'hFFFF_FFFF, 32'd1, 3'b010);
`endif
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
